// File: rtl/uart_pkg.sv
// Shared types for the flexible UART receiver: parity-mode codes, receiver states, held-word flags.
// Pure declarations; no latency or flow control of its own.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic break_det;
    } rx_flags_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick source: fractional accumulator adds BAUD*OVERSAMPLE per clk and ticks on wrap past CLK_FREQ.
// Tick is combinational off the accumulator; sync_clr zeroes the phase and suppresses that cycle's tick.
module uart_os_tick_gen #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_clr,
    output logic tick
);

    // acc stays below CLK_FREQ and the increment never exceeds it, so one extra bit holds the sum.
    localparam int            AW   = $clog2(CLK_FREQ) + 1;
    localparam logic [AW-1:0] INC  = AW'(BAUD * OVERSAMPLE);
    localparam logic [AW-1:0] WRAP = AW'(CLK_FREQ);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] sum;

    always_comb begin
        sum   = acc_q + INC;
        acc_d = sum;
        tick  = 1'b0;
        if (sync_clr) begin
            acc_d = '0;
        end else if (sum >= WRAP) begin
            acc_d = sum - WRAP;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_rx_flex.sv
// Oversampling UART receiver with parity/stop checking, break detection and a one-word valid/ready output stage.
// Word appears one clk after the last stop-bit decision; if the held word is not taken, the new frame is dropped and overrun pulses.
module uart_rx_flex #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    if (OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_flex: OVERSAMPLE must be even and within 4..32");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx_flex: DATA_BITS must be within 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_par
        $error("uart_rx_flex: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_rx_flex: STOP_BITS must be 1 or 2");
    end
    if (BAUD < 1 || longint'(CLK_FREQ) < longint'(BAUD) * longint'(OVERSAMPLE)) begin : g_bad_rate
        $error("uart_rx_flex: CLK_FREQ must be at least BAUD*OVERSAMPLE");
    end

    localparam int             TCW       = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] T_S0      = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] T_S1      = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] T_DEC     = TCW'(OVERSAMPLE / 2 + 1);
    localparam logic [TCW-1:0] T_LAST    = TCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    logic                 rxd_s1_q, rxd_s1_d;
    logic                 rxd_s2_q, rxd_s2_d;
    logic                 rxd_prev_q, rxd_prev_d;
    rx_state_e            state_q, state_d;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_any_low_q, stop_any_low_d;
    logic                 stop_all_low_q, stop_all_low_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    rx_flags_t            flags_q, flags_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 overrun_q, overrun_d;

    logic      tick;
    logic      sync_clr;
    logic      complete;
    logic      bit_val;
    logic      at_dec;
    logic      at_last;
    rx_flags_t new_flags;

    uart_os_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .sync_clr (sync_clr),
        .tick     (tick)
    );

    always_comb begin
        rxd_s1_d       = rxd;
        rxd_s2_d       = rxd_s1_q;
        rxd_prev_d     = rxd_s2_q;
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        samp_d         = samp_q;
        shift_d        = shift_q;
        par_bit_d      = par_bit_q;
        stop_any_low_d = stop_any_low_q;
        stop_all_low_d = stop_all_low_q;
        rx_data_d      = rx_data_q;
        flags_d        = flags_q;
        rx_valid_d     = rx_valid_q;
        overrun_d      = 1'b0;
        sync_clr       = 1'b0;
        complete       = 1'b0;

        // Third sample is taken live at the decision tick, so the bit is known one tick earlier.
        bit_val = maj3(samp_q[1], samp_q[0], rxd_s2_q);
        at_dec  = tick && (tick_cnt_q == T_DEC);
        at_last = tick && (tick_cnt_q == T_LAST);

        if (state_q != ST_IDLE && tick) begin
            tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + TCW'(1);
            if (tick_cnt_q == T_S0 || tick_cnt_q == T_S1) begin
                samp_d = {samp_q[0], rxd_s2_q};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    state_d        = ST_START;
                    sync_clr       = 1'b1;
                    tick_cnt_d     = '0;
                    bit_cnt_d      = '0;
                    par_bit_d      = 1'b0;
                    stop_any_low_d = 1'b0;
                    stop_all_low_d = 1'b1;
                end
            end
            ST_START: begin
                if (at_dec && bit_val) begin
                    state_d = ST_IDLE;
                end else if (at_last) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_dec) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                end
                if (at_last) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_dec) begin
                    par_bit_d = bit_val;
                end
                if (at_last) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // The frame closes at the last stop decision, leaving half a bit to catch a back-to-back start.
                if (at_dec) begin
                    stop_any_low_d = stop_any_low_q | ~bit_val;
                    stop_all_low_d = stop_all_low_q & ~bit_val;
                    if (bit_cnt_q == STOP_LAST) begin
                        complete = 1'b1;
                        state_d  = rxd_s2_q ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
                if (at_last && bit_cnt_q != STOP_LAST) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxd_s2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        new_flags.parity_err = (PARITY == PAR_NONE) ? 1'b0
                             : (((^shift_q) ^ par_bit_q) != (PARITY == PAR_ODD));
        new_flags.frame_err  = stop_any_low_d;
        new_flags.break_det  = (shift_q == '0) && !par_bit_q && stop_all_low_d;

        if (complete) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                flags_d    = new_flags;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q       <= 1'b1;
            rxd_s2_q       <= 1'b1;
            rxd_prev_q     <= 1'b1;
            state_q        <= ST_IDLE;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            samp_q         <= '0;
            shift_q        <= '0;
            par_bit_q      <= 1'b0;
            stop_any_low_q <= 1'b0;
            stop_all_low_q <= 1'b1;
            rx_data_q      <= '0;
            flags_q        <= '0;
            rx_valid_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            rxd_s1_q       <= rxd_s1_d;
            rxd_s2_q       <= rxd_s2_d;
            rxd_prev_q     <= rxd_prev_d;
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            samp_q         <= samp_d;
            shift_q        <= shift_d;
            par_bit_q      <= par_bit_d;
            stop_any_low_q <= stop_any_low_d;
            stop_all_low_q <= stop_all_low_d;
            rx_data_q      <= rx_data_d;
            flags_q        <= flags_d;
            rx_valid_q     <= rx_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = flags_q.parity_err;
    assign frame_err  = flags_q.frame_err;
    assign break_det  = flags_q.break_det;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_flex.md
UART_RX_FLEX -- requirements
Module: uart_rx_flex

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, 16, sample ticks per bit; even, 4..32.
REQ-004 Parameter DATA_BITS, 8, data bits per frame; 5..9.
REQ-005 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-006 Parameter STOP_BITS, 1, stop bits checked: 1 or 2.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 rst  input  1  reset; synchronous, active-high.
REQ-009 rxd  input  1  asynchronous serial line; idle high.
REQ-010 rx_data  output  DATA_BITS  received word; LSB received first.
REQ-011 rx_valid  output  1  rx_data and flags are valid; held until accepted.
REQ-012 rx_ready  input  1  consumer accepts the word when rx_valid&&rx_ready.
REQ-013 parity_err  output  1  parity mismatch on the held word; 0 when PARITY=0.
REQ-014 frame_err  output  1  a stop bit sampled low on the held word.
REQ-015 break_det  output  1  held word is all zero, with parity and stop also low.
REQ-016 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 rxd SHALL pass a 2-flop synchroniser; all logic uses the synchronised value.
REQ-019 The tick SHALL come from a fractional accumulator: +BAUD*OVERSAMPLE per clk, wrap at CLK_FREQ; mean error is 0.
REQ-020 The tick accumulator SHALL reset to 0 on every start-bit edge so bit phase is aligned to that edge.
REQ-021 States SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; PARITY is skipped when PARITY=0.
REQ-022 IDLE->START on a synchronised 1->0 transition of rxd.
REQ-023 Each bit value SHALL be the majority of 3 samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-024 In START, a majority of 1 SHALL return to IDLE (false start) with no output.
REQ-025 DATA SHALL shift DATA_BITS bits LSB-first, then go to PARITY or STOP.
REQ-026 parity_err = (XOR of data bits ^ parity bit) != (PARITY==2).
REQ-027 STOP SHALL check STOP_BITS bits; any low stop bit sets frame_err.
REQ-028 After the last stop-bit decision the frame SHALL complete: if the line is low, go to WAIT_IDLE; otherwise go to IDLE.
REQ-029 WAIT_IDLE SHALL hold until the line reads high, then go to IDLE; a break produces exactly one frame.
REQ-030 On completion, rx_data and the flags SHALL be loaded and rx_valid set on the next clk.
REQ-031 If rx_valid=1 and rx_ready=0 at completion, the new frame SHALL be dropped, held data is unchanged, and overrun pulses for 1 clk.
REQ-032 If rx_ready=1 in the cycle a frame completes, the held word is accepted and the new word loaded; no overrun.
REQ-033 rx_valid SHALL clear on the clk after acceptance unless a new word loads in that cycle.

Reset
REQ-034 rst SHALL force IDLE, clear the tick accumulator and bit counters, and set the synchroniser flops to 1.
REQ-035 Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, break_det=0, overrun=0, busy=0.
REQ-036 rst mid-frame SHALL abandon the frame without output; reception restarts at the next falling edge.

Structure
REQ-037 Package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the receiver state enum.
REQ-038 Tick generation SHALL be a sub-module uart_os_tick_gen (ports: clk, rst, sync_clr, tick).
REQ-039 Elaboration SHALL fail for out-of-range parameters or when CLK_FREQ < BAUD*OVERSAMPLE.

Verification (CLK_FREQ=16000000, BAUD=1000000, OVERSAMPLE=16: one tick per clk, 16 clk per bit)
REQ-040 8N1, frame 0xA5, rx_ready=1 -> rx_valid for 1 clk, rx_data=0xA5, all flags 0.
REQ-041 PARITY=1, 0x03 sent with parity bit 1 -> rx_data=0x03, parity_err=1; the same frame with parity bit 0 -> parity_err=0.
REQ-042 Low glitch of 5 clk on an idle line -> no rx_valid, busy returns to 0 within 16 clk.
REQ-043 Stop bit driven low on frame 0x5A -> frame_err=1; line held low for 30 bits -> exactly one rx_valid with break_det=1, then normal reception after the line goes high.
REQ-044 Frames 0x11 then 0x22 sent with rx_ready=0 -> rx_data stays 0x11, overrun pulses once; after rx_ready=1 -> rx_valid=0.
REQ-045 rst asserted during data bit 4 -> all outputs 0 next clk; next frame 0x3C is received correctly.
